mod_n_cascade_counter: RTL and testbench
========================================

MOD_N_CASCADE_COUNTER -- requirements
Module: mod_n_cascade_counter

Interface
REQ-001 The block SHALL have parameter MODULUS, default 10, count modulus per digit (2..256).
REQ-002 The block SHALL have parameter DIGITS, default 2, number of cascaded digits (1..8).
REQ-003 The block SHALL have derived localparam W = clog2(MODULUS), bit width per digit; not overridable.
REQ-004 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 The block SHALL have port en  input  1  count enable.
REQ-007 The block SHALL have port up  input  1  direction: 1 = up, 0 = down.
REQ-008 The block SHALL have port load  input  1  synchronous parallel load.
REQ-009 The block SHALL have port d  input  DIGITS*W  load value; digit i at bits [i*W +: W], digit 0 least significant.
REQ-010 The block SHALL have port q  output  DIGITS*W  registered count, same packing as d.
REQ-011 The block SHALL have port tc  output  1  combinational terminal count.
REQ-012 The block SHALL have port wrap  output  1  registered one-cycle wrap pulse.
REQ-013 The block SHALL have port load_err  output  1  sticky out-of-range-load flag.

Function
REQ-014 Per-cycle priority SHALL be: reset, then load, then en; with none active, q holds.
REQ-015 On load, each digit SHALL take d digit value if < MODULUS, else 0; the count takes effect the next cycle.
REQ-016 A load with any digit >= MODULUS SHALL set load_err at the next edge; load_err stays 1 until reset.
REQ-017 With en=1, up=1 and no load: digit 0 SHALL step +1; digit i>0 SHALL step only when all lower digits equal MODULUS-1.
REQ-018 With en=1, up=0 and no load: digit 0 SHALL step -1; digit i>0 SHALL step only when all lower digits equal 0.
REQ-019 Wrap-around SHALL occur per digit: MODULUS-1 steps to 0 when counting up; 0 steps to MODULUS-1 when counting down.
REQ-020 tc SHALL equal en & ~load & (all digits at MODULUS-1 if up, all digits 0 if down).
REQ-021 wrap SHALL be 1 for exactly the cycle after an edge at which tc was 1, else 0.
REQ-022 Changing up between cycles SHALL take effect on the next edge with no lost or extra step.
REQ-023 load and en asserted together SHALL perform only the load, with tc=0 and no wrap.
REQ-024 Count latency from en to q change SHALL be one clock.
REQ-025 q SHALL never hold a digit value >= MODULUS in any state reachable from reset.

Reset
REQ-026 At a rising clk edge with reset=0, the block SHALL set q = 0, wrap = 0 and load_err = 0, regardless of load or en.
REQ-027 reset SHALL have no asynchronous effect; a mid-count reset SHALL abort the count at the edge with no residual wrap pulse.
REQ-028 tc SHALL follow REQ-020 during reset; in the cycle after reset, q = 0, so tc = en & ~up & ~load.

Structure
REQ-029 Top-level parameters SHALL be module parameters; no shared package is required; clog2 SHALL use the codebase's common constant function if one exists.
REQ-030 One sub-module SHALL exist: mod_n_digit, a single W-bit mod-MODULUS up/down digit with inputs clk, reset, step, up, load, d and outputs q and at_term.
REQ-031 The top SHALL instantiate DIGITS copies of mod_n_digit through a generate loop and form the step enables by an AND chain of lower at_term signals.
REQ-032 All state SHALL be in flip-flops clocked on clk only, with no latches and no gated clocks.

Verification (DIGITS=2, MODULUS=10)
REQ-033 Release reset, hold en=1, up=1 for 100 cycles -> q steps 00,01..99,00; tc=1 only at 99; wrap=1 only in the cycle q=00.
REQ-034 Load d=8'h05 with up=0, then en=1 for 6 cycles -> q=05,04,03,02,01,00,99; tc=1 at 00; wrap pulse at 99.
REQ-035 Load d=8'h3C (low digit 12) -> q=30 next cycle and load_err=1; load_err stays 1 until reset=0.
REQ-036 At q=99 with up=1, assert load=1 (d=8'h42) and en=1 together -> q=42, tc=0, no wrap.
REQ-037 Count to q=47, then pull reset=0 for one cycle with en=1 -> q=00, wrap=0, load_err=0; counting resumes 01 the next cycle.
REQ-038 At q=50, toggle up every cycle with en=1 -> q=51,50,51,50; tc stays 0.

Source files
------------

// File: rtl/mod_n_cascade_counter_pkg.sv
// Shared constants and helpers for the mod-N cascade counter.
// No logic, no latency.
// No flow control.
package mod_n_cascade_counter_pkg;

  // Smallest bit count able to hold the values 0..value-1 (at least 1 bit).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One W-bit mod-MODULUS up/down digit with synchronous load and reset.
// q updates one clock after step/load; at_term is combinational from q and up.
// No backpressure; step is honoured on every edge it is high.
module mod_n_digit
  import mod_n_cascade_counter_pkg::*;
#(
  parameter int MODULUS = 10,
  parameter int W       = clog2(MODULUS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         at_term
);

  localparam logic [W-1:0] MAX_VAL = W'(MODULUS - 1);
  localparam logic [W:0]   MOD_EXT = (W+1)'(MODULUS);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next digit value: load wins over step; out-of-range load values collapse to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = ({1'b0, d} < MOD_EXT) ? d : '0;
    end else if (step) begin
      if (up) begin
        cnt_d = (cnt_q == MAX_VAL) ? '0 : cnt_q + 1'b1;
      end else begin
        cnt_d = (cnt_q == '0) ? MAX_VAL : cnt_q - 1'b1;
      end
    end
  end

  // Digit register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q       = cnt_q;
  // The digit is about to wrap if it steps in the current direction.
  assign at_term = up ? (cnt_q == MAX_VAL) : (cnt_q == '0);

endmodule

// File: rtl/mod_n_cascade_counter.sv
// DIGITS-digit cascaded mod-MODULUS up/down counter with load, tc, wrap and load_err.
// q, wrap and load_err are registered (1 clock); tc is combinational.
// No backpressure; en is acted on every edge unless load or reset take priority.
module mod_n_cascade_counter
  import mod_n_cascade_counter_pkg::*;
#(
  parameter  int MODULUS = 10,
  parameter  int DIGITS  = 2,
  localparam int W       = clog2(MODULUS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [DIGITS*W-1:0] d,
  output logic [DIGITS*W-1:0] q,
  output logic                tc,
  output logic                wrap,
  output logic                load_err
);

  localparam logic [W:0] MOD_EXT = (W+1)'(MODULUS);

  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] at_term;
  logic [DIGITS-1:0] oor;
  logic [W-1:0]      dig_q [DIGITS];

  logic wrap_q;
  logic wrap_d;
  logic load_err_q;
  logic load_err_d;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    // A digit steps only when every lower digit is at its terminal value.
    if (i == 0) begin : g_lsd
      assign step[i] = en;
    end else begin : g_upper
      assign step[i] = en & (&at_term[i-1:0]);
    end

    mod_n_digit #(
      .MODULUS (MODULUS),
      .W       (W)
    ) u_digit (
      .clk     (clk),
      .reset   (reset),
      .step    (step[i]),
      .up      (up),
      .load    (load),
      .d       (d[i*W +: W]),
      .q       (dig_q[i]),
      .at_term (at_term[i])
    );

    assign q[i*W +: W] = dig_q[i];
    assign oor[i]      = ({1'b0, d[i*W +: W]} >= MOD_EXT);
  end

  // Whole counter is at its terminal value and will roll over on this edge.
  assign tc = en & ~load & (&at_term);

  // wrap echoes tc one cycle later; load_err accumulates any out-of-range load.
  always_comb begin
    wrap_d     = tc;
    load_err_d = load_err_q | (load & (|oor));
  end

  // Status flags with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_mod_n_cascade_counter.sv
// Self-checking bench for mod_n_cascade_counter (MODULUS=10, DIGITS=2).
// Directed scenarios use literal expectations; the random phase uses a value-level model.
// Inputs change 1 time unit after the rising edge; outputs are sampled away from it.
module tb_mod_n_cascade_counter;

  localparam int MODULUS = 10;
  localparam int DIGITS  = 2;
  localparam int W       = 4;
  localparam int DW      = DIGITS * W;
  localparam int TOTAL   = MODULUS ** DIGITS;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          up = 1'b1;
  logic          load = 1'b0;
  logic [DW-1:0] d = '0;
  logic [DW-1:0] q;
  logic          tc;
  logic          wrap;
  logic          load_err;

  int checks = 0;
  int errors = 0;

  // Reference model: whole count as one integer 0..TOTAL-1.
  int m_val  = 0;
  bit m_wrap = 1'b0;
  bit m_err  = 1'b0;

  always #5 clk = ~clk;

  mod_n_cascade_counter #(
    .MODULUS (MODULUS),
    .DIGITS  (DIGITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .d        (d),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  function automatic logic [DW-1:0] enc(input int v);
    logic [DW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*W +: W] = W'(x % MODULUS);
      x = x / MODULUS;
    end
    return r;
  endfunction

  function automatic int load_value(input logic [DW-1:0] dv);
    int v;
    int p;
    v = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(dv[i*W +: W]) < MODULUS) v += int'(dv[i*W +: W]) * p;
      p *= MODULUS;
    end
    return v;
  endfunction

  function automatic bit load_bad(input logic [DW-1:0] dv);
    bit b;
    b = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(dv[i*W +: W]) >= MODULUS) b = 1'b1;
    end
    return b;
  endfunction

  function automatic bit exp_tc();
    return en && !load && (up ? (m_val == TOTAL - 1) : (m_val == 0));
  endfunction

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [DW-1:0] dv);
    reset = r;
    en    = e;
    up    = u;
    load  = l;
    d     = dv;
    #1;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic cyc();
    bit t;
    t = exp_tc();
    @(posedge clk);
    if (!reset) begin
      m_val  = 0;
      m_wrap = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_wrap = t;
      if (load) begin
        m_err = m_err | load_bad(d);
        m_val = load_value(d);
      end else if (en) begin
        m_val = up ? (m_val + 1) % TOTAL : (m_val + TOTAL - 1) % TOTAL;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(0, 1, 1, 1, 8'h3C);
    cyc();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %b want 0", load_err); end
    drive(0, 1, 0, 0, 8'h00);
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL reset_tc_down: got %b want 1", tc); end
    cyc();
    drive(1, 0, 1, 0, 8'h00);
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_no_wrap: got %b want 0", wrap); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc_idle: got %b want 0", tc); end
    cyc();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_hold_q: got %h want 00", q); end
  endtask

  task automatic test_count_up();
    drive(0, 0, 1, 0, 8'h00);
    cyc();
    drive(1, 1, 1, 0, 8'h00);
    for (int k = 1; k <= 100; k++) begin
      checks++;
      if (tc !== ((k - 1) == 99)) begin errors++; $display("FAIL up_tc step %0d: got %b", k, tc); end
      cyc();
      checks++;
      if (q !== enc(k % 100)) begin errors++; $display("FAIL up_q step %0d: got %h want %h", k, q, enc(k % 100)); end
      checks++;
      if (wrap !== (k == 100)) begin errors++; $display("FAIL up_wrap step %0d: got %b", k, wrap); end
    end
  endtask

  task automatic test_count_down();
    logic [DW-1:0] seq [6];
    seq = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99};
    drive(1, 0, 0, 1, 8'h05);
    cyc();
    checks++; if (q !== 8'h05) begin errors++; $display("FAIL down_load: got %h want 05", q); end
    drive(1, 1, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (tc !== (i == 5)) begin errors++; $display("FAIL down_tc step %0d: got %b", i, tc); end
      cyc();
      checks++;
      if (q !== seq[i]) begin errors++; $display("FAIL down_q step %0d: got %h want %h", i, q, seq[i]); end
      checks++;
      if (wrap !== (i == 5)) begin errors++; $display("FAIL down_wrap step %0d: got %b", i, wrap); end
    end
  endtask

  task automatic test_load_err();
    drive(1, 0, 1, 1, 8'h3C);
    cyc();
    checks++; if (q !== 8'h30) begin errors++; $display("FAIL lerr_q: got %h want 30", q); end
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL lerr_set: got %b want 1", load_err); end
    drive(1, 0, 1, 1, 8'h12);
    cyc();
    checks++; if (q !== 8'h12) begin errors++; $display("FAIL lerr_valid_q: got %h want 12", q); end
    drive(1, 1, 1, 0, 8'h00);
    repeat (3) cyc();
    checks++; if (q !== 8'h15) begin errors++; $display("FAIL lerr_count_q: got %h want 15", q); end
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL lerr_sticky: got %b want 1", load_err); end
    drive(0, 0, 1, 0, 8'h00);
    cyc();
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL lerr_clear: got %b want 0", load_err); end
  endtask

  task automatic test_load_over_en();
    drive(1, 0, 1, 1, 8'h99);
    cyc();
    drive(1, 1, 1, 1, 8'h42);
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL ldEn_tc: got %b want 0", tc); end
    cyc();
    checks++; if (q !== 8'h42) begin errors++; $display("FAIL ldEn_q: got %h want 42", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL ldEn_wrap: got %b want 0", wrap); end
  endtask

  task automatic test_mid_reset();
    drive(1, 0, 1, 1, 8'h4F);
    cyc();
    checks++; if (q !== 8'h40) begin errors++; $display("FAIL mrst_load_q: got %h want 40", q); end
    drive(1, 1, 1, 0, 8'h00);
    repeat (7) cyc();
    checks++; if (q !== 8'h47) begin errors++; $display("FAIL mrst_pre_q: got %h want 47", q); end
    drive(0, 1, 1, 0, 8'h00);
    cyc();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL mrst_q: got %h want 00", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL mrst_wrap: got %b want 0", wrap); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL mrst_lerr: got %b want 0", load_err); end
    drive(1, 1, 1, 0, 8'h00);
    cyc();
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL mrst_resume: got %h want 01", q); end
    drive(1, 0, 1, 1, 8'h99);
    cyc();
    drive(0, 1, 1, 0, 8'h00);
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL mrst_tc99: got %b want 1", tc); end
    cyc();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL mrst_residual_wrap: got %b want 0", wrap); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL mrst_q99: got %h want 00", q); end
  endtask

  task automatic test_toggle_dir();
    logic u;
    drive(1, 0, 1, 1, 8'h50);
    cyc();
    for (int i = 0; i < 4; i++) begin
      u = (i % 2 == 0);
      drive(1, 1, u, 0, 8'h00);
      checks++;
      if (tc !== 1'b0) begin errors++; $display("FAIL toggle_tc step %0d: got %b", i, tc); end
      cyc();
      checks++;
      if (q !== (u ? 8'h51 : 8'h50)) begin errors++; $display("FAIL toggle_q step %0d: got %h", i, q); end
    end
  endtask

  task automatic test_random();
    logic          r;
    logic          e;
    logic          u;
    logic          l;
    logic [DW-1:0] dv;
    u = 1'b1;
    drive(0, 0, 1, 0, 8'h00);
    cyc();
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 59) != 0);
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) u = ~u;
      l = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       dv = 8'h99;
        1:       dv = 8'h00;
        default: dv = DW'($urandom);
      endcase
      drive(r, e, u, l, dv);
      checks++;
      if (tc !== exp_tc()) begin errors++; $display("FAIL rand_tc cyc %0d: got %b want %b", n, tc, exp_tc()); end
      cyc();
      checks++;
      if (q !== enc(m_val)) begin errors++; $display("FAIL rand_q cyc %0d: got %h want %h", n, q, enc(m_val)); end
      checks++;
      if (wrap !== m_wrap) begin errors++; $display("FAIL rand_wrap cyc %0d: got %b want %b", n, wrap, m_wrap); end
      checks++;
      if (load_err !== m_err) begin errors++; $display("FAIL rand_load_err cyc %0d: got %b want %b", n, load_err, m_err); end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_count_up();
    test_count_down();
    test_load_err();
    test_load_over_en();
    test_mid_reset();
    test_toggle_dir();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
